// File: rtl/bus_arbiter.sv
// Bus arbiter between the CPU and two DMA channels, with round-robin between the channels.
// Latency: from an idle CPU with its slot used up, a request is granted 2 clocks later (CPU -> GAP -> DMA).
// Backpressure: no grant is taken away during an open cycle; CPU and DMA hand over only when cyc is low.
module bus_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 255,
  parameter int CPU_SLOT     = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cpu_cyc_i,
  output logic       cpu_gnt_o,
  input  logic [1:0] dma_req_i,
  input  logic [1:0] dma_cyc_i,
  input  logic       wb_ack_i,
  output logic [1:0] dma_gnt_o,
  output logic [1:0] owner_o
);

  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);
  localparam logic [7:0] LP_IDLE_TO   = 8'(IDLE_TIMEOUT);
  localparam logic [3:0] LP_SLOT      = 4'(CPU_SLOT);

  typedef enum logic [1:0] {
    S_CPU      = 2'd0,
    S_GAP      = 2'd1,
    S_DMA      = 2'd2,
    S_HANDBACK = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_sel;        // channel being granted, or about to be
  logic       r_last;       // channel served most recently; the other one wins a tie
  logic [3:0] r_slot;
  logic [7:0] r_burst;
  logic [7:0] r_idle;
  logic       r_cpu_gnt;
  logic [1:0] r_dma_gnt;
  logic [1:0] r_owner;

  logic       w_sel_cyc;
  logic       w_sel_req;
  logic       w_pick;
  logic       w_cpu_release;
  logic       w_dma_release;

  // Only the selected channel's strobes matter; the other channel waits for the next arbitration.
  assign w_sel_cyc = dma_cyc_i[r_sel];
  assign w_sel_req = dma_req_i[r_sel];

  // A lone requester wins. If both request, the channel not served last wins.
  assign w_pick = (&dma_req_i) ? ~r_last : dma_req_i[1];

  // The CPU gives up the bus only between its own cycles, and only after its slot has elapsed.
  assign w_cpu_release = (|dma_req_i) & ~cpu_cyc_i & (r_slot == LP_SLOT);

  // The DMA gives up the bus only between cycles: when it stops requesting, its burst is used up, or it has been idle too long.
  assign w_dma_release = ~w_sel_cyc &
                         (~w_sel_req | (r_burst == LP_MAX_BURST) | (r_idle == LP_IDLE_TO));

  assign cpu_gnt_o = r_cpu_gnt;
  assign dma_gnt_o = r_dma_gnt;
  assign owner_o   = r_owner;

  // Ownership state machine. Grants and owner are registered so they never glitch.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_CPU;
      r_sel     <= 1'b0;
      r_last    <= 1'b1;
      r_slot    <= '0;
      r_burst   <= '0;
      r_idle    <= '0;
      r_cpu_gnt <= 1'b1;
      r_dma_gnt <= 2'b00;
      r_owner   <= 2'd0;
    end else begin
      case (r_state)
        S_CPU: begin
          if (r_slot != LP_SLOT) r_slot <= r_slot + 4'd1;
          if (w_cpu_release) begin
            r_state   <= S_GAP;
            r_sel     <= w_pick;
            r_cpu_gnt <= 1'b0;
            r_owner   <= 2'd3;
          end
        end
        S_GAP: begin
          r_state   <= S_DMA;
          r_last    <= r_sel;
          r_dma_gnt <= r_sel ? 2'b10 : 2'b01;
          r_owner   <= r_sel ? 2'd2 : 2'd1;
        end
        S_DMA: begin
          if (w_sel_cyc && wb_ack_i && (r_burst != LP_MAX_BURST)) r_burst <= r_burst + 8'd1;
          if (w_sel_cyc)                r_idle <= '0;
          else if (r_idle != LP_IDLE_TO) r_idle <= r_idle + 8'd1;
          if (w_dma_release) begin
            r_state   <= S_HANDBACK;
            r_dma_gnt <= 2'b00;
            r_owner   <= 2'd3;
          end
        end
        default: begin
          r_state   <= S_CPU;
          r_cpu_gnt <= 1'b1;
          r_dma_gnt <= 2'b00;
          r_owner   <= 2'd0;
          r_slot    <= '0;
          r_burst   <= '0;
          r_idle    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, checked each clock against an ownership model.
// The model follows the arbitration rules in terms of who owns the bus, elapsed clocks, acks and idle clocks.
// Inputs change on the falling edge; outputs are sampled on the falling edge or just after an asynchronous reset.
module tb_bus_arbiter;

  localparam int MAX_BURST    = 8;
  localparam int IDLE_TIMEOUT = 16;
  localparam int CPU_SLOT     = 4;

  localparam int PH_CPU = 0;
  localparam int PH_GAP = 1;
  localparam int PH_DMA = 2;
  localparam int PH_HB  = 3;

  logic       wb_clk_i  = 1'b0;
  logic       wb_rst_i  = 1'b0;
  logic       cpu_cyc_i = 1'b0;
  logic       cpu_gnt_o;
  logic [1:0] dma_req_i = 2'b00;
  logic [1:0] dma_cyc_i = 2'b00;
  logic       wb_ack_i  = 1'b0;
  logic [1:0] dma_gnt_o;
  logic [1:0] owner_o;

  int errors = 0;
  int checks = 0;

  // Model state: who holds the bus, how long the CPU has held it, and the acks and idle clocks of the current DMA grant
  int m_phase, m_sel, m_last, m_slot, m_burst, m_idle;

  bus_arbiter #(.MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT), .CPU_SLOT(CPU_SLOT)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cpu_cyc_i(cpu_cyc_i),
    .cpu_gnt_o(cpu_gnt_o),
    .dma_req_i(dma_req_i),
    .dma_cyc_i(dma_cyc_i),
    .wb_ack_i (wb_ack_i),
    .dma_gnt_o(dma_gnt_o),
    .owner_o  (owner_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic void model_reset();
    m_phase = PH_CPU; m_sel = 0; m_last = 1; m_slot = 0; m_burst = 0; m_idle = 0;
  endfunction

  function automatic void model_step(input bit cc, input bit [1:0] rq, input bit [1:0] cy, input bit ak);
    case (m_phase)
      PH_CPU: begin
        if (rq != 2'b00 && !cc && m_slot >= CPU_SLOT) begin
          if (rq == 2'b11) m_sel = 1 - m_last;
          else             m_sel = rq[1] ? 1 : 0;
          m_phase = PH_GAP;
        end
        if (m_slot < CPU_SLOT) m_slot++;
      end
      PH_GAP: begin
        m_phase = PH_DMA;
        m_last  = m_sel;
      end
      PH_DMA: begin
        bit busy = cy[m_sel];
        bit done = !busy && (!rq[m_sel] || m_burst == MAX_BURST || m_idle == IDLE_TIMEOUT);
        if (busy && ak && m_burst < MAX_BURST) m_burst++;
        if (busy) m_idle = 0;
        else if (m_idle < IDLE_TIMEOUT) m_idle++;
        if (done) m_phase = PH_HB;
      end
      default: begin
        m_phase = PH_CPU; m_slot = 0; m_burst = 0; m_idle = 0;
      end
    endcase
  endfunction

  function automatic bit exp_cpu();
    return m_phase == PH_CPU;
  endfunction

  function automatic bit [1:0] exp_dma();
    if (m_phase != PH_DMA) return 2'b00;
    return (m_sel != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic bit [1:0] exp_owner();
    if (m_phase == PH_CPU) return 2'd0;
    if (m_phase == PH_DMA) return 2'(m_sel + 1);
    return 2'd3;
  endfunction

  // Apply one clock of stimulus, advance the model on the edge, and return on the following falling edge
  task automatic tick(input bit cc, input bit [1:0] rq, input bit [1:0] cy, input bit ak);
    cpu_cyc_i = cc; dma_req_i = rq; dma_cyc_i = cy; wb_ack_i = ak;
    @(posedge wb_clk_i);
    if (wb_rst_i) model_reset();
    else          model_step(cc, rq, cy, ak);
    @(negedge wb_clk_i);
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    cpu_cyc_i = 1'b0; dma_req_i = 2'b00; dma_cyc_i = 2'b00; wb_ack_i = 1'b0;
    model_reset();
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    model_reset();
    #1;
    if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {1'b1, 2'b00, 2'd0}) begin
      errors++;
      $display("FAIL reset_now: got cpu=%b dma=%b own=%0d, want cpu=1 dma=00 own=0", cpu_gnt_o, dma_gnt_o, owner_o);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
      if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {1'b1, 2'b00, 2'd0}) begin
        errors++;
        $display("FAIL reset_held: got cpu=%b dma=%b own=%0d, want cpu=1 dma=00 own=0", cpu_gnt_o, dma_gnt_o, owner_o);
      end
      checks++;
    end
    wb_rst_i = 1'b0;
  endtask

  task automatic test_first_grant();
    int gap_cnt = 0;
    bit [1:0] first_dma = 2'b00;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 2'b01, 2'b00, 1'b0);
      if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {exp_cpu(), exp_dma(), exp_owner()}) begin
        errors++;
        $display("FAIL first_grant: got cpu=%b dma=%b own=%0d, want cpu=%b dma=%b own=%0d",
                 cpu_gnt_o, dma_gnt_o, owner_o, exp_cpu(), exp_dma(), exp_owner());
      end
      checks++;
      if (owner_o == 2'd3 && first_dma == 2'b00) gap_cnt++;
      if (dma_gnt_o != 2'b00 && first_dma == 2'b00) first_dma = dma_gnt_o;
    end
    if (gap_cnt !== 1 || first_dma !== 2'b01) begin
      errors++;
      $display("FAIL first_grant_gap: got gap=%0d grant=%b, want gap=1 grant=01", gap_cnt, first_dma);
    end
    checks++;
  endtask

  task automatic test_round_robin();
    int order[$];
    bit served = 1'b0;
    bit [1:0] prev_gnt = 2'b00;
    do_reset();
    for (int i = 0; i < 400 && order.size() < 5; i++) begin
      bit [1:0] cy = 2'b00;
      bit ak = 1'b0;
      if (m_phase == PH_DMA && !served) begin
        cy[m_sel] = 1'b1; ak = 1'b1; served = 1'b1;
      end
      if (m_phase == PH_CPU) served = 1'b0;
      tick(1'b0, 2'b11, cy, ak);
      if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {exp_cpu(), exp_dma(), exp_owner()}) begin
        errors++;
        $display("FAIL round_robin: got cpu=%b dma=%b own=%0d, want cpu=%b dma=%b own=%0d",
                 cpu_gnt_o, dma_gnt_o, owner_o, exp_cpu(), exp_dma(), exp_owner());
      end
      checks++;
      if (prev_gnt == 2'b00 && dma_gnt_o != 2'b00) order.push_back(dma_gnt_o[1] ? 1 : 0);
      prev_gnt = dma_gnt_o;
    end
    if (order.size() != 5) begin
      errors++;
      $display("FAIL round_robin_timeout: got %0d grants, want 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (order[k] !== (k % 2)) begin
          errors++;
          $display("FAIL round_robin_order: grant %0d went to channel %0d, want %0d", k, order[k], k % 2);
        end
        checks++;
      end
    end
  endtask

  task automatic test_burst();
    int total = 0, in_grant = 0, cpu_run = 0, min_cpu = 1000;
    int acks[$];
    bit prev_dma = 1'b0, prev_cpu = 1'b1;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      bit [1:0] cy = 2'b00;
      bit ak = 1'b0;
      if (m_phase == PH_DMA && m_sel == 0 && in_grant < MAX_BURST && total < 20) begin
        cy = 2'b01; ak = 1'b1; in_grant++; total++;
      end
      tick(1'b0, (total < 20) ? 2'b01 : 2'b00, cy, ak);
      if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {exp_cpu(), exp_dma(), exp_owner()}) begin
        errors++;
        $display("FAIL burst: got cpu=%b dma=%b own=%0d, want cpu=%b dma=%b own=%0d",
                 cpu_gnt_o, dma_gnt_o, owner_o, exp_cpu(), exp_dma(), exp_owner());
      end
      checks++;
      if (prev_dma && dma_gnt_o == 2'b00) begin acks.push_back(in_grant); in_grant = 0; end
      if (cpu_gnt_o) cpu_run++;
      else if (prev_cpu) begin if (cpu_run < min_cpu) min_cpu = cpu_run; cpu_run = 0; end
      prev_dma = (dma_gnt_o != 2'b00);
      prev_cpu = cpu_gnt_o;
    end
    if (acks.size() != 3) begin
      errors++;
      $display("FAIL burst_grants: got %0d grants, want 3", acks.size());
    end else if (acks[0] != MAX_BURST || acks[1] != MAX_BURST || acks[2] != 20 - 2 * MAX_BURST) begin
      errors++;
      $display("FAIL burst_split: got %0d+%0d+%0d, want 8+8+4", acks[0], acks[1], acks[2]);
    end
    checks++;
    if (min_cpu < CPU_SLOT) begin
      errors++;
      $display("FAIL burst_cpu_slot: got shortest CPU hold %0d, want at least %0d", min_cpu, CPU_SLOT);
    end
    checks++;
  endtask

  task automatic test_cpu_busy();
    do_reset();
    repeat (6) tick(1'b0, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 2'b10, 2'b00, 1'b0);
      if (cpu_gnt_o !== 1'b1 || cpu_gnt_o !== exp_cpu()) begin
        errors++;
        $display("FAIL cpu_busy_hold: got cpu=%b, want cpu=1", cpu_gnt_o);
      end
      checks++;
    end
    tick(1'b0, 2'b10, 2'b00, 1'b0);
    if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {1'b0, 2'b00, 2'd3}) begin
      errors++;
      $display("FAIL cpu_busy_gap: got cpu=%b dma=%b own=%0d, want cpu=0 dma=00 own=3", cpu_gnt_o, dma_gnt_o, owner_o);
    end
    checks++;
    tick(1'b0, 2'b10, 2'b00, 1'b0);
    if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {1'b0, 2'b10, 2'd2}) begin
      errors++;
      $display("FAIL cpu_busy_grant: got cpu=%b dma=%b own=%0d, want cpu=0 dma=10 own=2", cpu_gnt_o, dma_gnt_o, owner_o);
    end
    checks++;
  endtask

  task automatic test_idle_timeout();
    int held = 1;
    int wait_cnt = 0;
    do_reset();
    while (dma_gnt_o !== 2'b10 && wait_cnt < 20) begin
      tick(1'b0, 2'b10, 2'b00, 1'b0);
      wait_cnt++;
    end
    if (dma_gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL idle_wait_grant: got dma=%b, want 10 within 20 clocks", dma_gnt_o);
    end
    checks++;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 2'b10, 2'b00, 1'b0);
      if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {exp_cpu(), exp_dma(), exp_owner()}) begin
        errors++;
        $display("FAIL idle: got cpu=%b dma=%b own=%0d, want cpu=%b dma=%b own=%0d",
                 cpu_gnt_o, dma_gnt_o, owner_o, exp_cpu(), exp_dma(), exp_owner());
      end
      checks++;
      if (dma_gnt_o == 2'b10) held++;
      else break;
    end
    if (held !== IDLE_TIMEOUT + 1 || owner_o !== 2'd3) begin
      errors++;
      $display("FAIL idle_revoke: got held=%0d own=%0d, want held=%0d own=3", held, owner_o, IDLE_TIMEOUT + 1);
    end
    checks++;
    tick(1'b0, 2'b10, 2'b00, 1'b0);
    if (cpu_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_handback: got cpu=%b, want 1", cpu_gnt_o);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    int wait_cnt = 0;
    do_reset();
    while (dma_gnt_o !== 2'b01 && wait_cnt < 20) begin
      tick(1'b0, 2'b01, 2'b00, 1'b0);
      wait_cnt++;
    end
    tick(1'b0, 2'b01, 2'b01, 1'b1);
    tick(1'b0, 2'b01, 2'b01, 1'b1);
    if (dma_gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL async_setup: got dma=%b, want 01", dma_gnt_o);
    end
    checks++;
    #2 wb_rst_i = 1'b1;
    model_reset();
    #1;
    if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {1'b1, 2'b00, 2'd0}) begin
      errors++;
      $display("FAIL async_reset: got cpu=%b dma=%b own=%0d, want cpu=1 dma=00 own=0", cpu_gnt_o, dma_gnt_o, owner_o);
    end
    checks++;
    tick(1'b0, 2'b01, 2'b01, 1'b1);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'b00, 2'b00, 1'b0);
      if (dma_gnt_o !== 2'b00 || {cpu_gnt_o, dma_gnt_o, owner_o} !== {exp_cpu(), exp_dma(), exp_owner()}) begin
        errors++;
        $display("FAIL async_release: got cpu=%b dma=%b own=%0d, want cpu=1 dma=00 own=0", cpu_gnt_o, dma_gnt_o, owner_o);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    bit [1:0] rq = 2'b00, cy = 2'b00;
    bit cc = 1'b0, ak = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
        if ($urandom_range(0, 5) == 0) cy[b] = ~cy[b];
      end
      if ($urandom_range(0, 3) == 0) cc = ~cc;
      ak = 1'($urandom_range(0, 1));
      tick(cc, rq, cy, ak);
      if ({cpu_gnt_o, dma_gnt_o, owner_o} !== {exp_cpu(), exp_dma(), exp_owner()}) begin
        errors++;
        $display("FAIL random cycle %0d: got cpu=%b dma=%b own=%0d, want cpu=%b dma=%b own=%0d",
                 i, cpu_gnt_o, dma_gnt_o, owner_o, exp_cpu(), exp_dma(), exp_owner());
      end
      checks++;
      if ($countones({cpu_gnt_o, dma_gnt_o}) > 1) begin
        errors++;
        $display("FAIL random_onehot cycle %0d: got cpu=%b dma=%b, want at most one grant", i, cpu_gnt_o, dma_gnt_o);
      end
      checks++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_round_robin();
    test_burst();
    test_cpu_busy();
    test_idle_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
